// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: occupancy encoding, reset/exception
// constants and per-stage payload layouts packed into in_data.
package pipe_pkg;

  localparam int PC_W_DEFAULT   = 32;
  localparam int DATA_W_DEFAULT = 160;

  localparam logic [31:0] EXC_VEC_DEFAULT = 32'h0000_4180;
  localparam logic [31:0] PC_RESET        = 32'h0000_0000;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  // M->W bundle, exactly DATA_W_DEFAULT bits
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc8;
    logic [31:0] alu;
    logic [31:0] mdu;
    logic [26:0] cp0;
    logic [4:0]  rd;
  } mw_payload_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc8;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [26:0] ctrl;
    logic [4:0]  rd;
  } em_payload_t;

  function automatic logic [1:0] occ_count(
    input logic main_v,
    input logic skid_v
  );
    logic [1:0] occ;
    unique case ({main_v, skid_v})
      2'b00:   occ = OCC_EMPTY;
      2'b11:   occ = OCC_FULL;
      default: occ = OCC_ONE;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready stage link carrying a PC, a packed payload and a bubble mark.
// The consumer side ignores the bubble mark of incoming entries.
interface pipe_stage_skid_if
  import pipe_pkg::*;
#(
  parameter int PC_W   = PC_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
);

  logic              valid;
  logic              ready;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] data;
  logic              bubble;

  modport master (
    output valid,
    output pc,
    output data,
    output bubble,
    input  ready
  );

  modport slave (
    input  valid,
    input  pc,
    input  data,
    output ready
  );

endinterface

// File: rtl/pipe_entry_reg.sv
// One held pipeline entry: valid/pc/data/bubble with inject, clear,
// load and drop controls (in that priority order).
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int PC_W   = PC_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              inject,
  input  logic              clear,
  input  logic              load,
  input  logic              drop,
  input  logic [PC_W-1:0]   inj_pc,
  input  logic [PC_W-1:0]   pc_d,
  input  logic [DATA_W-1:0] data_d,
  input  logic              bubble_d,
  output logic              valid,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] data,
  output logic              bubble
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid  <= 1'b0;
      pc     <= PC_RESET[PC_W-1:0];
      data   <= '0;
      bubble <= 1'b0;
    end else if (inject) begin
      valid  <= 1'b1;
      pc     <= inj_pc;
      data   <= '0;
      bubble <= 1'b1;
    end else if (clear) begin
      valid  <= 1'b0;
      pc     <= PC_RESET[PC_W-1:0];
      data   <= '0;
      bubble <= 1'b0;
    end else if (load) begin
      valid  <= 1'b1;
      pc     <= pc_d;
      data   <= data_d;
      bubble <= bubble_d;
    end else if (drop) begin
      // pc/data keep the departed entry; only the marks clear
      valid  <= 1'b0;
      bubble <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic inter-stage register: 1-cycle latency, optional 2-entry skid,
// flush and exception-bubble injection.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int          PC_W    = PC_W_DEFAULT,
  parameter int          DATA_W  = DATA_W_DEFAULT,
  parameter logic [31:0] EXC_VEC = EXC_VEC_DEFAULT,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  pipe_stage_skid_if.slave  up,
  pipe_stage_skid_if.master dn,
  input  logic       flush,
  input  logic       exc_req,
  output logic [1:0] occupancy
);

  localparam logic [PC_W-1:0] EXC_PC = EXC_VEC[PC_W-1:0];

  logic              main_v;
  logic [PC_W-1:0]   main_pc;
  logic [DATA_W-1:0] main_data;
  logic              main_bub;
  logic              skid_v;
  logic [PC_W-1:0]   skid_pc;
  logic [DATA_W-1:0] skid_data;
  logic              skid_bub;

  logic              in_fire;
  logic              out_fire;
  logic              main_from_skid;
  logic              main_load;
  logic              main_drop;
  logic              skid_load;
  logic              skid_drop;
  logic [PC_W-1:0]   main_pc_d;
  logic [DATA_W-1:0] main_data_d;
  logic              main_bub_d;

  generate
    if (SKID_EN) begin : g_skid
      assign up.ready = !skid_v;
    end else begin : g_single
      assign up.ready = !main_v | dn.ready;
    end
  endgenerate

  assign in_fire  = up.valid & up.ready;
  assign out_fire = main_v & dn.ready;

  always_comb begin
    main_from_skid = skid_v & out_fire;
    main_load      = main_from_skid
                   | (in_fire & (!main_v | out_fire));
    main_drop      = out_fire & !main_load;
    // accepted while main is stalled: park it behind main
    skid_load      = SKID_EN & in_fire & main_v & !out_fire;
    skid_drop      = main_from_skid;
    main_pc_d      = up.pc;
    main_data_d    = up.data;
    main_bub_d     = 1'b0;
    if (main_from_skid) begin
      main_pc_d   = skid_pc;
      main_data_d = skid_data;
      main_bub_d  = skid_bub;
    end
  end

  pipe_entry_reg #(
    .PC_W   (PC_W),
    .DATA_W (DATA_W)
  ) u_main (
    .clk      (clk),
    .reset_n  (reset_n),
    .inject   (exc_req),
    .clear    (flush),
    .load     (main_load),
    .drop     (main_drop),
    .inj_pc   (EXC_PC),
    .pc_d     (main_pc_d),
    .data_d   (main_data_d),
    .bubble_d (main_bub_d),
    .valid    (main_v),
    .pc       (main_pc),
    .data     (main_data),
    .bubble   (main_bub)
  );

  pipe_entry_reg #(
    .PC_W   (PC_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk      (clk),
    .reset_n  (reset_n),
    .inject   (1'b0),
    .clear    (flush | exc_req),
    .load     (skid_load),
    .drop     (skid_drop),
    .inj_pc   (EXC_PC),
    .pc_d     (up.pc),
    .data_d   (up.data),
    .bubble_d (1'b0),
    .valid    (skid_v),
    .pc       (skid_pc),
    .data     (skid_data),
    .bubble   (skid_bub)
  );

  assign dn.valid  = main_v;
  assign dn.pc     = main_pc;
  assign dn.data   = main_data;
  assign dn.bubble = main_bub;
  assign occupancy = occ_count(main_v, skid_v);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: skid and single-register builds side by side,
// each checked against a queue model of held entries.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int          PC_W   = 32;
  localparam int          DATA_W = 160;
  localparam logic [31:0] EXC    = 32'h0000_4180;

  typedef struct {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;
    logic              bub;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       flush = 1'b0;
  logic       exc_req = 1'b0;
  logic [1:0] occ1;
  logic [1:0] occ0;

  int checks = 0;
  int errors = 0;

  pipe_stage_skid_if #(.PC_W(PC_W), .DATA_W(DATA_W)) in1 ();
  pipe_stage_skid_if #(.PC_W(PC_W), .DATA_W(DATA_W)) out1 ();
  pipe_stage_skid_if #(.PC_W(PC_W), .DATA_W(DATA_W)) in0 ();
  pipe_stage_skid_if #(.PC_W(PC_W), .DATA_W(DATA_W)) out0 ();

  pipe_stage_skid #(
    .PC_W(PC_W), .DATA_W(DATA_W), .EXC_VEC(EXC), .SKID_EN(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .up(in1), .dn(out1),
    .flush(flush), .exc_req(exc_req), .occupancy(occ1)
  );

  pipe_stage_skid #(
    .PC_W(PC_W), .DATA_W(DATA_W), .EXC_VEC(EXC), .SKID_EN(1'b0)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .up(in0), .dn(out0),
    .flush(flush), .exc_req(exc_req), .occupancy(occ0)
  );

  always #5 clk = ~clk;

  ent_t              q1[$];
  ent_t              q0[$];
  logic [PC_W-1:0]   last_pc1 = '0;
  logic [PC_W-1:0]   last_pc0 = '0;
  logic [DATA_W-1:0] last_d1 = '0;
  logic [DATA_W-1:0] last_d0 = '0;

  task automatic chk(input string tag,
                     input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check_outs(input bit r0);
    bit v1;
    bit v0;
    v1 = q1.size() > 0;
    v0 = q0.size() > 0;
    chk("skid.out_valid", out1.valid, v1);
    chk("skid.out_pc", out1.pc, last_pc1);
    chk("skid.out_data", out1.data, last_d1);
    chk("skid.out_bubble", out1.bubble, v1 ? q1[0].bub : 1'b0);
    chk("skid.occupancy", occ1, q1.size());
    chk("skid.in_ready", in1.ready, q1.size() < 2);
    chk("single.out_valid", out0.valid, v0);
    chk("single.out_pc", out0.pc, last_pc0);
    chk("single.out_data", out0.data, last_d0);
    chk("single.out_bubble", out0.bubble, v0 ? q0[0].bub : 1'b0);
    chk("single.occupancy", occ0, q0.size());
    chk("single.in_ready", in0.ready, !v0 || r0);
  endtask

  task automatic clear_model();
    q1.delete();
    q0.delete();
    last_pc1 = '0;
    last_pc0 = '0;
    last_d1  = '0;
    last_d0  = '0;
  endtask

  task automatic cycle(input bit v, input logic [PC_W-1:0] pc,
                       input logic [DATA_W-1:0] d, input bit r1,
                       input bit r0, input bit fl, input bit ex);
    ent_t e;
    bit   out_ok;
    bit   in_ok;
    in1.valid  = v;
    in1.pc     = pc;
    in1.data   = d;
    in0.valid  = v;
    in0.pc     = pc;
    in0.data   = d;
    out1.ready = r1;
    out0.ready = r0;
    flush      = fl;
    exc_req    = ex;
    #1;
    check_outs(r0);
    @(posedge clk);
    if (ex) begin
      q1.delete();
      q0.delete();
      e = '{EXC[PC_W-1:0], '0, 1'b1};
      q1.push_back(e);
      q0.push_back(e);
    end else if (fl) begin
      clear_model();
    end else begin
      e = '{pc, d, 1'b0};
      in_ok  = q1.size() < 2;
      out_ok = q1.size() > 0 && r1;
      if (out_ok) void'(q1.pop_front());
      if (v && in_ok) q1.push_back(e);
      in_ok  = q0.size() == 0 || r0;
      out_ok = q0.size() > 0 && r0;
      if (out_ok) void'(q0.pop_front());
      if (v && in_ok) q0.push_back(e);
    end
    if (q1.size() > 0) begin
      last_pc1 = q1[0].pc;
      last_d1  = q1[0].data;
    end
    if (q0.size() > 0) begin
      last_pc0 = q0[0].pc;
      last_d0  = q0[0].data;
    end
    @(negedge clk);
  endtask

  initial begin
    in1.valid = 1'b0; in1.pc = '0; in1.data = '0; in1.bubble = 1'b0;
    in0.valid = 1'b0; in0.pc = '0; in0.data = '0; in0.bubble = 1'b0;
    out1.ready = 1'b0;
    out0.ready = 1'b0;
    #3;
    check_outs(1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // streaming at full rate
    cycle(1, 32'h3000, rnd_data(), 1, 1, 0, 0);
    cycle(1, 32'h3004, rnd_data(), 1, 1, 0, 0);
    cycle(1, 32'h3008, rnd_data(), 1, 1, 0, 0);
    cycle(0, 32'h0, '0, 1, 1, 0, 0);
    cycle(0, 32'h0, '0, 1, 1, 0, 0);

    // back-pressure fills the skid, then drains in order
    cycle(1, 32'h3000, rnd_data(), 0, 0, 0, 0);
    cycle(1, 32'h3004, rnd_data(), 0, 0, 0, 0);
    cycle(1, 32'h3010, rnd_data(), 0, 0, 0, 0);
    cycle(0, 32'h0, '0, 1, 1, 0, 0);
    cycle(0, 32'h0, '0, 1, 1, 0, 0);
    cycle(0, 32'h0, '0, 1, 1, 0, 0);

    // flush while full, with a competing input
    cycle(1, 32'h3000, rnd_data(), 0, 0, 0, 0);
    cycle(1, 32'h3004, rnd_data(), 0, 0, 0, 0);
    cycle(1, 32'h300C, rnd_data(), 0, 0, 1, 0);
    cycle(0, 32'h0, '0, 1, 1, 0, 0);
    cycle(0, 32'h0, '0, 1, 1, 0, 0);

    // exception beats flush; bubble then drains like any entry
    cycle(1, 32'h3020, rnd_data(), 0, 0, 0, 0);
    cycle(1, 32'h3024, rnd_data(), 0, 0, 0, 0);
    cycle(1, 32'h3028, rnd_data(), 0, 0, 1, 1);
    cycle(1, 32'h302C, rnd_data(), 0, 0, 0, 0);
    cycle(1, 32'h3030, rnd_data(), 1, 1, 0, 0);
    cycle(0, 32'h0, '0, 1, 1, 0, 0);
    cycle(0, 32'h0, '0, 1, 1, 0, 0);

    // asynchronous reset while full
    cycle(1, 32'h3040, rnd_data(), 0, 0, 0, 0);
    cycle(1, 32'h3044, rnd_data(), 0, 0, 0, 0);
    in1.valid = 1'b0;
    in0.valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    clear_model();
    check_outs(1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    cycle(0, 32'h0, '0, 1, 1, 0, 0);
    cycle(0, 32'h0, '0, 1, 1, 0, 0);

    // single-register build under toggling out_ready
    cycle(1, 32'h3100, rnd_data(), 1, 1, 0, 0);
    cycle(1, 32'h3104, rnd_data(), 1, 0, 0, 0);
    cycle(1, 32'h3108, rnd_data(), 1, 1, 0, 0);
    cycle(1, 32'h310C, rnd_data(), 1, 0, 0, 0);
    cycle(1, 32'h3110, rnd_data(), 1, 1, 0, 0);
    cycle(0, 32'h0, '0, 1, 1, 0, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) < 7,
            {$urandom_range(0, 32'hFFFF), 2'b00},
            rnd_data(),
            $urandom_range(0, 9) < 6,
            $urandom_range(0, 9) < 6,
            $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 3);
    end
    cycle(0, 32'h0, '0, 1, 1, 0, 0);
    cycle(0, 32'h0, '0, 1, 1, 0, 0);
    cycle(0, 32'h0, '0, 1, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
